// File: rtl/pcie_dma_mwr_tlp_tx.sv
// ---------------------------------------------------------------------------
// pcie_dma_mwr_tlp_tx
//   Memory Write TLP transmit stage sitting behind the MWr BAR-RAM read
//   controller. Takes one DMA write command and asks the read controller for
//   the payload. It then emits a header beat followed by the payload beats on
//   a 128-bit AXI-stream-style TX port.
//
// Optional feature:
//   PCIE_DMA_MWR_TX_TIMEOUT_EN - adds a watchdog on WAIT_START. If no
//   i_gen_tlp_start arrives within TIMEOUT_CYC cycles, the command is
//   abandoned and o_err pulses for one cycle. When the macro is undefined,
//   o_err is tied 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready         command handshake (accepted only in IDLE)
//   i_cmd_addr/length/tag, i_req_id command fields (length 0 means 1024 DW)
//   o_rd_en, o_rd_length            read request to the read controller
//   o_mwr_tx_busy, o_mwr_tx_hold    TLP in progress / TX back-pressure
//   o_mwr_tlp_tx                    payload beat consumed
//   i_gen_tlp_start, i_rd_data      first-beat-ready flag and payload beat
//   i_last_data                     last-beat flag (cross-checked only)
//   o_axis_t*, i_axis_tready        TX stream toward the PCIe core
//   o_done, o_err                   completion / abort pulses
// ---------------------------------------------------------------------------

// Cross-check: the read controller's last flag must match the beat counter.
module pcie_dma_mwr_tlp_tx_chk (
  input  logic clk,
  input  logic rst_n,
  input  logic beat_acc,
  input  logic last_beat,
  input  logic last_data
);
  a_last_match: assert property (@(posedge clk) disable iff (!rst_n)
                                 beat_acc |-> (last_data == last_beat));
endmodule

module pcie_dma_mwr_tlp_tx #(
  parameter logic [15:0] REQ_ID_DEF  = 16'h0000,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [63:0]  i_cmd_addr,
  input  logic [9:0]   i_cmd_length,
  input  logic [7:0]   i_cmd_tag,
  input  logic [15:0]  i_req_id,
  output logic         o_rd_en,
  output logic [9:0]   o_rd_length,
  output logic         o_mwr_tx_busy,
  output logic         o_mwr_tx_hold,
  output logic         o_mwr_tlp_tx,
  input  logic         i_gen_tlp_start,
  input  logic [127:0] i_rd_data,
  input  logic         i_last_data,
  output logic         o_axis_tvalid,
  input  logic         i_axis_tready,
  output logic [127:0] o_axis_tdata,
  output logic [3:0]   o_axis_tkeep,
  output logic         o_axis_tlast,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HDR   = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [61:0]   addr_q, addr_d;     // byte address bits [63:2]
  logic [9:0]    len_q, len_d;
  logic [7:0]    tag_q, tag_d;
  logic [15:0]   rid_q, rid_d;
  logic [8:0]    beats_q, beats_d;   // payload beats still to send
  logic          start_q, start_d;   // start pulse seen during REQ/WAIT

  logic [10:0]   len_ext_s, beats_sum_s;
  logic          is_4dw_s, last_beat_s, beat_acc_s, err_s;
  logic [3:0]    last_be_s, last_keep_s;
  logic [31:0]   dw0_s, dw1_s, dw2_s, dw3_s;
  logic          unused_ok_s;

`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
  logic [15:0]   to_cnt_q, to_cnt_d;
  assign unused_ok_s = ^i_cmd_addr[1:0];
`else
  assign unused_ok_s = ^{i_cmd_addr[1:0], TIMEOUT_CYC};
`endif

  // Header fields: a 4DW header is needed only when the upper address is non-zero.
  always_comb begin
    is_4dw_s    = |addr_q[61:30];
    last_be_s   = (len_q == 10'd1) ? 4'h0 : 4'hF;
    dw0_s       = {(is_4dw_s ? 3'b011 : 3'b010), 5'b00000, 8'h00, 6'b000000, len_q};
    dw1_s       = {rid_q, tag_q, last_be_s, 4'hF};
    dw2_s       = is_4dw_s ? addr_q[61:30] : {addr_q[29:0], 2'b00};
    dw3_s       = is_4dw_s ? {addr_q[29:0], 2'b00} : 32'h0000_0000;
    // Length 0 encodes 1024 DW, so extend to 11 bits before rounding up.
    len_ext_s   = {(i_cmd_length == 10'd0), i_cmd_length};
    beats_sum_s = len_ext_s + 11'd3;
    case (len_q[1:0])
      2'd0:    last_keep_s = 4'hF;
      2'd1:    last_keep_s = 4'h1;
      2'd2:    last_keep_s = 4'h3;
      2'd3:    last_keep_s = 4'h7;
      default: last_keep_s = 4'hF;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    tag_d         = tag_q;
    rid_d         = rid_q;
    beats_d       = beats_q;
    start_d       = 1'b0;
    o_rd_en       = 1'b0;
    o_mwr_tx_busy = 1'b0;
    o_axis_tvalid = 1'b0;
    o_axis_tdata  = 128'd0;
    o_axis_tkeep  = 4'h0;
    o_axis_tlast  = 1'b0;
    o_mwr_tlp_tx  = 1'b0;
    o_done        = 1'b0;
    err_s         = 1'b0;
    last_beat_s   = (beats_q == 9'd1);
    beat_acc_s    = 1'b0;
`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
    to_cnt_d      = 16'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          addr_d  = i_cmd_addr[63:2];
          len_d   = i_cmd_length;
          tag_d   = i_cmd_tag;
          rid_d   = (i_req_id == 16'h0000) ? REQ_ID_DEF : i_req_id;
          beats_d = beats_sum_s[10:2];
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        o_rd_en       = 1'b1;
        o_mwr_tx_busy = 1'b1;
        start_d       = i_gen_tlp_start;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        o_rd_en       = 1'b1;
        o_mwr_tx_busy = 1'b1;
        start_d       = start_q | i_gen_tlp_start;
        if (start_q || i_gen_tlp_start) begin
          state_d = S_HDR;
`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
        end else if (to_cnt_q == (TIMEOUT_CYC - 16'd1)) begin
          err_s   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
`else
        end else begin
`endif
          state_d = S_WAIT;
        end
      end
      S_HDR: begin
        o_rd_en       = 1'b1;
        o_mwr_tx_busy = 1'b1;
        o_axis_tvalid = 1'b1;
        o_axis_tdata  = {dw3_s, dw2_s, dw1_s, dw0_s};
        o_axis_tkeep  = 4'hF;
        if (i_axis_tready) begin
          state_d = S_DATA;
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        o_rd_en       = 1'b1;
        o_mwr_tx_busy = 1'b1;
        o_axis_tvalid = 1'b1;
        o_axis_tdata  = i_rd_data;
        o_axis_tkeep  = last_beat_s ? last_keep_s : 4'hF;
        o_axis_tlast  = last_beat_s;
        if (i_axis_tready) begin
          o_mwr_tlp_tx = 1'b1;
          beat_acc_s   = 1'b1;
          beats_d      = beats_q - 9'd1;
          state_d      = last_beat_s ? S_DONE : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  assign o_mwr_tx_hold = o_axis_tvalid & ~i_axis_tready;
  assign o_rd_length   = len_q;
  assign o_cmd_ready   = ready_q;
  assign o_err         = err_s;

  // State and command latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= 62'd0;
      len_q    <= 10'd0;
      tag_q    <= 8'd0;
      rid_q    <= 16'd0;
      beats_q  <= 9'd0;
      start_q  <= 1'b0;
`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
      to_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      tag_q    <= tag_d;
      rid_q    <= rid_d;
      beats_q  <= beats_d;
      start_q  <= start_d;
`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  pcie_dma_mwr_tlp_tx_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_acc  (beat_acc_s),
    .last_beat (last_beat_s),
    .last_data (i_last_data)
  );

endmodule

// File: tb/tb_pcie_dma_mwr_tlp_tx.sv
module tb_pcie_dma_mwr_tlp_tx;

`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
  localparam logic [15:0] TB_TO = 16'd16;
`else
  localparam logic [15:0] TB_TO = 16'd4096;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [63:0]  i_cmd_addr;
  logic [9:0]   i_cmd_length;
  logic [7:0]   i_cmd_tag;
  logic [15:0]  i_req_id;
  logic         o_rd_en;
  logic [9:0]   o_rd_length;
  logic         o_mwr_tx_busy, o_mwr_tx_hold, o_mwr_tlp_tx;
  logic         i_gen_tlp_start;
  logic [127:0] i_rd_data;
  logic         i_last_data;
  logic         o_axis_tvalid, i_axis_tready;
  logic [127:0] o_axis_tdata;
  logic [3:0]   o_axis_tkeep;
  logic         o_axis_tlast, o_done, o_err;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic         hdr;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int tr_mode = 0;      // 0: tready high, 1: toggle every cycle
  int start_dly = 2;    // cycles from rd_en rise to start pulse, -1 = never
  int cur_beats = 1;
  logic [7:0] cur_tag = 8'h00;
  int rd_idx;

  pcie_dma_mwr_tlp_tx #(.REQ_ID_DEF(16'h0000), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_length(i_cmd_length),
    .i_cmd_tag(i_cmd_tag), .i_req_id(i_req_id),
    .o_rd_en(o_rd_en), .o_rd_length(o_rd_length),
    .o_mwr_tx_busy(o_mwr_tx_busy), .o_mwr_tx_hold(o_mwr_tx_hold),
    .o_mwr_tlp_tx(o_mwr_tlp_tx), .i_gen_tlp_start(i_gen_tlp_start),
    .i_rd_data(i_rd_data), .i_last_data(i_last_data),
    .o_axis_tvalid(o_axis_tvalid), .i_axis_tready(i_axis_tready),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep),
    .o_axis_tlast(o_axis_tlast), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [7:0] tag, input int k);
    logic [31:0] kk;
    kk = k;
    return {tag, kk[23:0], 32'hC0DE_0000 + kk, ~kk, 32'h1234_5678 ^ kk};
  endfunction

  // Read-controller model: start pulse after rd_en rises, advance on consumption.
  initial begin : rd_ctrl
    logic acc, ren, ren_prev;
    int cnt;
    ren_prev = 1'b0; cnt = -1; rd_idx = 0;
    i_gen_tlp_start = 1'b0; i_rd_data = 128'd0; i_last_data = 1'b0;
    forever begin
      @(negedge clk);
      acc = o_mwr_tlp_tx; ren = o_rd_en;
      @(posedge clk); #1;
      i_gen_tlp_start = 1'b0;
      if (ren && !ren_prev) begin
        rd_idx = 0; cnt = start_dly;
      end else if (acc) begin
        rd_idx++;
      end
      ren_prev = ren;
      if (cnt == 0) begin
        i_gen_tlp_start = 1'b1; cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      i_rd_data   = beat_data(cur_tag, rd_idx);
      i_last_data = (rd_idx == cur_beats - 1);
    end
  end

  // TX ready driver.
  initial begin : tr_drv
    i_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tr_mode == 1) i_axis_tready = ~i_axis_tready;
      else i_axis_tready = 1'b1;
    end
  end

  // Monitor: pop and compare every accepted beat, plus hold/stability/done.
  initial begin : mon
    beat_t b;
    logic [127:0] prev_d;
    logic prev_held, done_exp;
    prev_held = 1'b0; done_exp = 1'b0; prev_d = 128'd0;
    forever begin
      @(negedge clk);
      if (o_done || done_exp) chk("done_pulse", 128'(o_done), 128'(done_exp));
      done_exp = 1'b0;
      if (o_axis_tvalid) begin
        chk("hold", 128'(o_mwr_tx_hold), 128'(!i_axis_tready));
        if (prev_held) chk("tdata_stable", o_axis_tdata, prev_d);
      end
      prev_held = o_axis_tvalid && !i_axis_tready;
      prev_d    = o_axis_tdata;
      if (o_axis_tvalid && i_axis_tready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got %h expected no beat", o_axis_tdata);
        end else begin
          b = sb.pop_front();
          chk("tdata", o_axis_tdata, b.data);
          chk("tkeep", 128'(o_axis_tkeep), 128'(b.keep));
          chk("tlast", 128'(o_axis_tlast), 128'(b.last));
          chk("tlp_tx", 128'(o_mwr_tlp_tx), 128'(!b.hdr));
          done_exp = b.last;
        end
      end
    end
  end

  task automatic send_cmd(input logic [63:0] addr, input logic [9:0] len,
                          input logic [7:0] tag, input logic [15:0] rid);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_length = len;
    i_cmd_tag = tag; i_req_id = rid;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept", 128'(ok), 128'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [63:0] addr, input logic [9:0] len,
                         input logic [7:0] tag, input logic [15:0] rid,
                         input logic [127:0] hdr, input int nb,
                         input logic [3:0] lkeep, input int mode, input bit abort);
    bit seen;
    tr_mode = mode; cur_beats = nb; cur_tag = tag;
    sb.push_back('{hdr, 4'hF, 1'b0, 1'b1});
    for (int k = 0; k < nb; k++)
      sb.push_back('{beat_data(tag, k), (k == nb - 1) ? lkeep : 4'hF, (k == nb - 1), 1'b0});
    send_cmd(addr, len, tag, rid);
    @(negedge clk);
    chk("rd_en", 128'(o_rd_en), 128'd1);
    chk("rd_length", 128'(o_rd_length), 128'(len));
    chk("busy", 128'(o_mwr_tx_busy), 128'd1);
    chk("ready_busy", 128'(o_cmd_ready), 128'd0);
    seen = 1'b0;
    if (abort) begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (o_mwr_tlp_tx) begin seen = 1'b1; break; end
      end
      chk("abort_beat1", 128'(seen), 128'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_outs", 128'({o_rd_en, o_mwr_tx_busy, o_axis_tvalid, o_axis_tlast,
                            o_mwr_tlp_tx, o_mwr_tx_hold, o_done, o_err, o_cmd_ready}), 128'd0);
      chk("rst_len", 128'(o_rd_length), 128'd0);
      sb.delete();
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 128'(o_cmd_ready), 128'd1);
      chk("rst_tvalid", 128'({o_axis_tvalid, o_rd_en}), 128'd0);
    end else begin
      for (int i = 0; i < 3000; i++) begin
        if (o_done) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      chk("done_seen", 128'(seen), 128'd1);
      chk("done_idle", 128'({o_rd_en, o_mwr_tx_busy}), 128'd0);
      chk("sb_empty", 128'(sb.size()), 128'd0);
      @(negedge clk);
      chk("ready_after", 128'(o_cmd_ready), 128'd1);
    end
  endtask

  initial begin : main
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_addr = 64'd0;
    i_cmd_length = 10'd0; i_cmd_tag = 8'd0; i_req_id = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 128'({o_cmd_ready, o_rd_en, o_mwr_tx_busy, o_axis_tvalid,
                            o_mwr_tlp_tx, o_done, o_err, o_axis_tlast}), 128'd0);
    chk("reset_data", o_axis_tdata, 128'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_post_rst", 128'(o_cmd_ready), 128'd1);

    run_cmd(64'h0000_0000_1000_0040, 10'd8, 8'h11, 16'hABCD,
            128'h0000_0000_1000_0040_ABCD_11FF_4000_0008, 2, 4'hF, 0, 1'b0);
    run_cmd(64'h0000_0001_0000_0000, 10'd5, 8'h22, 16'h0000,
            128'h0000_0000_0000_0001_0000_22FF_6000_0005, 2, 4'h1, 0, 1'b0);
    run_cmd(64'h0000_0000_0000_2003, 10'd1, 8'h33, 16'h1234,
            128'h0000_0000_0000_2000_1234_330F_4000_0001, 1, 4'h1, 0, 1'b0);
    run_cmd(64'h8000_0000_0000_1000, 10'd0, 8'h44, 16'h0000,
            128'h0000_1000_8000_0000_0000_44FF_6000_0000, 256, 4'hF, 0, 1'b0);
    run_cmd(64'h0000_0000_0000_0100, 10'd16, 8'h55, 16'h0001,
            128'h0000_0000_0000_0100_0001_55FF_4000_0010, 4, 4'hF, 1, 1'b0);
    run_cmd(64'h0000_0000_0000_0300, 10'd7, 8'h66, 16'h00FF,
            128'h0000_0000_0000_0300_00FF_66FF_4000_0007, 2, 4'h7, 0, 1'b0);
    run_cmd(64'h0000_0000_0000_0400, 10'd6, 8'h77, 16'h0F0F,
            128'h0000_0000_0000_0400_0F0F_77FF_4000_0006, 2, 4'h3, 1, 1'b0);
    run_cmd(64'h0000_0000_0000_0600, 10'd16, 8'h88, 16'h0003,
            128'h0000_0000_0000_0600_0003_88FF_4000_0010, 4, 4'hF, 0, 1'b1);
    run_cmd(64'h0000_0000_0000_0500, 10'd2, 8'h99, 16'h0002,
            128'h0000_0000_0000_0500_0002_99FF_4000_0002, 1, 4'h3, 0, 1'b0);

`ifdef PCIE_DMA_MWR_TX_TIMEOUT_EN
    begin : timeout_test
      bit tv_seen;
      int err_at;
      tv_seen = 1'b0; err_at = -1;
      start_dly = -1; tr_mode = 0;
      send_cmd(64'h0000_0000_0000_0700, 10'd4, 8'hAA, 16'h0000);
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (o_axis_tvalid) tv_seen = 1'b1;
        if (o_err) begin err_at = i; break; end
      end
      chk("err_cycle", 128'(err_at), 128'd17);
      chk("err_no_tvalid", 128'(tv_seen), 128'd0);
      @(negedge clk);
      chk("err_rd_en", 128'({o_rd_en, o_mwr_tx_busy, o_err}), 128'd0);
      chk("err_ready", 128'(o_cmd_ready), 128'd1);
      start_dly = 2;
    end
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_dma_mwr_tlp_tx.md
Name: pcie_dma_mwr_tlp_tx

Overview:
- MWr TLP transmit stage directly downstream of the MWr BAR-RAM read controller.
- Accepts one DMA write command (address, DW length, tag) and drives the read controller's rd_en/length/busy/hold/tlp_tx handshake.
- Consumes the 128-bit payload beats the read controller returns and emits a complete Memory Write TLP (header beat + payload beats) on a 128-bit AXI-stream-style TX port toward the PCIe core.

Parameters:
- REQ_ID_DEF, 16'h0000, requester ID used when i_req_id is 16'h0000.
- TIMEOUT_CYC, 16'd4096, WAIT_START watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  gen1 62.5MHz / gen2 125MHz.
- rst_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_cmd_addr  in  64  target byte address; bits[1:0] ignored.
- i_cmd_length  in  10  payload in DW; 0 = 1024.
- i_cmd_tag  in  8  TLP tag.
- i_req_id  in  16  requester ID.
- o_rd_en  out  1  to read ctrl; level, rise starts a read.
- o_rd_length  out  10  to read ctrl; latched length.
- o_mwr_tx_busy  out  1  to read ctrl; TLP in progress.
- o_mwr_tx_hold  out  1  to read ctrl; TX back-pressure.
- o_mwr_tlp_tx  out  1  to read ctrl; payload beat consumed.
- i_gen_tlp_start  in  1  from read ctrl; first payload beat ready.
- i_rd_data  in  128  from read ctrl; payload beat.
- i_last_data  in  1  from read ctrl; informational last-beat flag.
- o_axis_tvalid  out  1  TX beat valid.
- i_axis_tready  in  1  TX ready.
- o_axis_tdata  out  128  TX beat; DW0 in bits[31:0].
- o_axis_tkeep  out  4  per-DW enable.
- o_axis_tlast  out  1  last beat of the TLP.
- o_done  out  1  one-cycle pulse when the TLP completes.
- o_err  out  1  one-cycle pulse on abort (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: all outputs 0, except o_cmd_ready = 0 during reset and 1 in IDLE from the first clock after reset. FSM goes to IDLE; all counters and latches clear.
- FSM states: IDLE -> REQ -> WAIT_START -> HDR -> DATA -> DONE -> IDLE.
- IDLE:
  - o_cmd_ready = 1.
  - On valid&ready, latch addr, length, tag and req_id (REQ_ID_DEF if req_id == 0), then go to REQ.
- REQ:
  - o_rd_en = 1 and o_mwr_tx_busy = 1 from this state until DONE. o_rd_en must be 0 for at least one cycle between commands.
  - o_rd_length = latched length.
  - Next cycle goes to WAIT_START.
- WAIT_START: wait for i_gen_tlp_start = 1, then go to HDR. Any start pulse seen in REQ is also captured.
- HDR:
  - Drive tvalid = 1, tkeep = 4'hF.
  - If addr[63:32] == 0: 3DW header, fmt = 3'b010. Otherwise 4DW, fmt = 3'b011.
  - type = 5'b0, TC/attr = 0.
  - Length field = length[9:0], so 1024 encodes as 0.
  - First BE = 4'hF. Last BE = 4'hF if length ≠ 1, else 4'h0.
  - DW1 = {req_id, tag, lastBE, firstBE}.
  - DW2 = addr (3DW) or addr[63:32] (4DW). DW3 = addr[31:2],2'b00 (4DW) or 0 (3DW).
  - Header always occupies its own beat.
  - Leave HDR on tready.
- DATA:
  - tdata = i_rd_data; tvalid = 1.
  - o_mwr_tlp_tx = tvalid & tready.
  - o_mwr_tx_hold = tvalid & ~tready, combinational, in every state. tdata must remain stable while held.
  - Beat counter loads ceil(len/4) (1..256, 9 bits) and decrements per accepted beat.
  - Final beat: tlast = 1. tkeep = 4'hF/4'h1/4'h3/4'h7 for len%4 = 0/1/2/3.
  - All other beats: tkeep = 4'hF.
  - i_last_data is not used for termination; a mismatch is a sim assertion.
- DONE: o_done = 1 for one cycle; o_mwr_tx_busy drops; return to IDLE.
- Back-pressure: tready may drop on any beat including header and last. No beat is lost or duplicated.
- A new command is accepted only in IDLE, so there is no overlap.
- Reset mid-TLP: immediate return to IDLE with all outputs 0; the partial TLP is abandoned.

Optional Feature:
- Macro: PCIE_DMA_MWR_TX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_START.
  - On reaching TIMEOUT_CYC with no i_gen_tlp_start: drop o_rd_en/busy, pulse o_err for one cycle, return to IDLE. No AXIS beat is emitted.
- Undefined: no counter; WAIT_START waits indefinitely; o_err is tied 0.

Test Plan:
- addr=64'h0000_0000_1000_0040, len=8, tready=1 -> 3 beats.
  - HDR DW0 = 32'h4000_0008, DW2 = 32'h1000_0040.
  - 2 data beats with tkeep 4'hF; tlast on beat 3; o_mwr_tlp_tx pulses twice; o_done one cycle later.
- addr=64'h0000_0001_0000_0000, len=5 -> fmt 3'b011, DW2 = 32'h1, DW3 = 0; 2 data beats, last tkeep 4'h1.
- len=1 -> last BE 4'h0, one data beat with tkeep 4'h1; len=0 -> length field 0, 256 data beats.
- len=16, tready toggling 1/0 each cycle -> o_mwr_tx_hold = ~tready while tvalid; tdata stable while held; 5 beats total, none lost.
- rst_n low during DATA beat 2 -> next cycle all outputs 0, o_cmd_ready = 1; a following command completes normally.
- With PCIE_DMA_MWR_TX_TIMEOUT_EN and TIMEOUT_CYC=16, i_gen_tlp_start never asserted -> o_err pulse after 16 WAIT_START cycles, no tvalid, o_rd_en returns 0.
